fir_tx_sequencer: RTL



---
 rtl/fir_tx_sequencer_if.sv | 19 +
 rtl/fir_tx_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fir_tx_sequencer_if.sv
// Upstream symbol-bit valid/ready channel feeding fir_tx_sequencer.
// The source drives data/valid; the sequencer returns ready.
interface fir_tx_sequencer_if;
  logic i_bit_data;
  logic i_bit_valid;
  logic o_bit_ready;

  modport master (
    output i_bit_data,
    output i_bit_valid,
    input  o_bit_ready
  );

  modport slave (
    input  i_bit_data,
    input  i_bit_valid,
    output o_bit_ready
  );
endinterface

// File: rtl/fir_tx_sequencer.sv
// Control sequencer for the TX polyphase FIR: strobe divider, phase select,
// one-entry symbol holding register and IDLE/RUN/FLUSH run control.
// Optional PRBS9 symbol source is enabled by defining FIR_TX_SEQ_PRBS_EN.
module fir_tx_sequencer #(
  parameter int unsigned NB_DIV  = 8,
  parameter int unsigned N_FLUSH = 6,
  parameter int unsigned NB_CNT  = 16
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [NB_DIV-1:0]   i_div,
  input  logic                i_prbs_sel,
  fir_tx_sequencer_if.slave   src,
  output logic                o_enb_tx,
  output logic [1:0]          o_select_phase,
  output logic                o_tx_bit,
  output logic                o_busy,
  output logic                o_underrun,
  output logic [NB_CNT-1:0]   o_sym_count
);

  localparam int unsigned NB_FL = $clog2(N_FLUSH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [NB_DIV-1:0] div_lat;
  logic [NB_DIV-1:0] div_cnt;
  logic [1:0]        phase;
  logic              hold_full;
  logic              hold_bit;
  logic              stop_pend;
  logic [NB_FL-1:0]  flush_cnt;
  logic              flush_done;
  logic              strobe;
  logic              sym_strobe;
  logic              start_acc;
  logic              handshake;
  logic              prbs_active;
  logic              prbs_bit;

`ifdef FIR_TX_SEQ_PRBS_EN
  logic       prbs_lat;
  logic [8:0] lfsr;

  // Galois form of the PRBS9 register; lfsr[8] from seed 1FF yields 1,1,1,1,1,0,0,0,0.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prbs_lat <= 1'b0;
      lfsr     <= 9'h1FF;
    end else if (start_acc) begin
      prbs_lat <= i_prbs_sel;
      lfsr     <= 9'h1FF;
    end else if (prbs_lat && sym_strobe && (state == ST_RUN)) begin
      lfsr <= {lfsr[7:0], lfsr[8]} ^ {4'b0000, lfsr[8], 4'b0000};
    end
  end

  assign prbs_active = prbs_lat;
  assign prbs_bit    = lfsr[8];
`else
  logic unused_prbs_sel;

  assign unused_prbs_sel = i_prbs_sel;
  assign prbs_active     = 1'b0;
  assign prbs_bit        = 1'b0;
`endif

  assign src.o_bit_ready = (state == ST_RUN) && !hold_full && !prbs_active;
  assign handshake       = src.i_bit_valid && src.o_bit_ready;

  // FLUSH lingers one cycle past its last strobe so busy drops the cycle after it.
  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    flush_done = (state == ST_FLUSH) && (flush_cnt == NB_FL'(N_FLUSH));
    strobe     = (state != ST_IDLE) && !flush_done && (div_cnt == div_lat);
    sym_strobe = strobe && (phase == 2'd3);
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_RUN;
          start_acc = 1'b1;
        end
      end
      ST_RUN: begin
        if (sym_strobe && stop_pend) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      div_lat        <= '0;
      div_cnt        <= '0;
      phase          <= '0;
      stop_pend      <= 1'b0;
      flush_cnt      <= '0;
      o_enb_tx       <= 1'b0;
      o_select_phase <= '0;
      o_tx_bit       <= 1'b0;
      o_busy         <= 1'b0;
      o_underrun     <= 1'b0;
      o_sym_count    <= '0;
    end else begin
      state    <= state_nxt;
      o_busy   <= (state_nxt != ST_IDLE);
      o_enb_tx <= strobe;
      if (start_acc) begin
        div_lat     <= i_div;
        div_cnt     <= '0;
        phase       <= '0;
        stop_pend   <= 1'b0;
        flush_cnt   <= '0;
        o_underrun  <= 1'b0;
        o_sym_count <= '0;
      end else begin
        if (state != ST_IDLE) begin
          div_cnt <= strobe ? '0 : div_cnt + 1'b1;
        end
        if (strobe) begin
          o_select_phase <= phase;
          phase          <= phase + 2'd1;
        end
        if ((state == ST_RUN) && i_stop) begin
          stop_pend <= 1'b1;
        end
        if (sym_strobe) begin
          if (state == ST_RUN) begin
            o_sym_count <= o_sym_count + 1'b1;
            if (prbs_active) begin
              o_tx_bit <= prbs_bit;
            end else if (hold_full) begin
              o_tx_bit <= hold_bit;
            end else begin
              o_tx_bit   <= 1'b0;
              o_underrun <= 1'b1;
            end
          end else begin
            o_tx_bit  <= 1'b0;
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
      end
    end
  end

  // A fill wins over a same-cycle consume, so the new bit is never lost.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_full <= 1'b0;
      hold_bit  <= 1'b0;
    end else if (state_nxt != ST_RUN) begin
      hold_full <= 1'b0;
    end else if (handshake) begin
      hold_full <= 1'b1;
      hold_bit  <= src.i_bit_data;
    end else if (sym_strobe) begin
      hold_full <= 1'b0;
    end
  end

endmodule
